// File: rtl/biquad_pkg.sv
// Shared types and constants for the biquad sequencer: FSM states, tap selects, default widths.
package biquad_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int COEF_W_DEF = 18;
  localparam int FRAC_W_DEF = 16;
  localparam int ACC_W_DEF  = 56;

  localparam longint ROUND_HALF = 64'sd1 <<< (FRAC_W_DEF - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_TAP_SET,
    ST_TAP_MAC,
    ST_ROUND,
    ST_COMMIT
  } state_t;

  localparam logic [2:0] TAP_X0 = 3'd0;
  localparam logic [2:0] TAP_X1 = 3'd1;
  localparam logic [2:0] TAP_X2 = 3'd2;
  localparam logic [2:0] TAP_Y1 = 3'd3;
  localparam logic [2:0] TAP_Y2 = 3'd4;

endpackage

// File: rtl/biquad_round_sat.sv
// Round-half-up, shift out FRAC_W fractional bits, reduce to DATA_W (combinational).
// IIR_BIQUAD_SAT_EN defined: clamp to the signed DATA_W range; undefined: two's-complement wrap.
module biquad_round_sat #(
  parameter int ACC_W  = 56,
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic        [DATA_W-1:0] result
);
  localparam int QW = ACC_W - FRAC_W;
  localparam logic signed [ACC_W-1:0] HALF = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_W - 1);

  logic signed [ACC_W-1:0] rounded;
  logic signed [QW-1:0]    q;
  logic                    unused_bits;

  assign rounded = acc + HALF;
  // taking the upper bits is the arithmetic shift right by FRAC_W
  assign q = rounded[ACC_W-1:FRAC_W];

`ifdef IIR_BIQUAD_SAT_EN
  localparam logic signed [QW-1:0] MAX_V = {{(QW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [QW-1:0] MIN_V = ~MAX_V;

  always_comb begin
    result = q[DATA_W-1:0];
    if (q > MAX_V)
      result = {1'b0, {(DATA_W-1){1'b1}}};
    else if (q < MIN_V)
      result = {1'b1, {(DATA_W-1){1'b0}}};
  end

  assign unused_bits = ^rounded[FRAC_W-1:0];
`else
  assign result      = q[DATA_W-1:0];
  assign unused_bits = ^{rounded[FRAC_W-1:0], q[QW-1:DATA_W]};
`endif

endmodule

// File: rtl/iir_biquad_mac_seq.sv
// Direct-form-I biquad: one shared multiplier walks the five memory taps per sample.
// Accept-to-y_valid is 12 cycles, one sample per 14; x_ready stays low while busy.
module iir_biquad_mac_seq
  import biquad_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] x_in,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic [COEF_W-1:0] b0,
  input  logic [COEF_W-1:0] b1,
  input  logic [COEF_W-1:0] b2,
  input  logic [COEF_W-1:0] a1,
  input  logic [COEF_W-1:0] a2,
  input  logic [DATA_W-1:0] mem_out,
  output logic [2:0]        mem_dir,
  output logic [DATA_W-1:0] mem_x,
  output logic [DATA_W-1:0] mem_y,
  output logic              mem_x_enable,
  output logic              mem_y_enable,
  output logic [DATA_W-1:0] y_out,
  output logic              y_valid,
  output logic              busy
);
  localparam int PROD_W = DATA_W + COEF_W;

  state_t                   state, state_n;
  logic [2:0]               tap;
  logic signed [COEF_W-1:0] coef [5];
  logic signed [COEF_W-1:0] coef_sel;
  logic signed [ACC_W-1:0]  acc;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic [DATA_W-1:0]        result;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n      = state;
    x_ready      = 1'b0;
    mem_x_enable = 1'b0;
    mem_y_enable = 1'b0;
    y_valid      = 1'b0;
    busy         = 1'b1;
    mem_dir      = TAP_X0;
    case (state)
      ST_IDLE: begin
        busy    = 1'b0;
        x_ready = ~reset;
        if (x_valid) state_n = ST_LOAD;
      end
      ST_LOAD: begin
        mem_x_enable = 1'b1;
        state_n      = ST_TAP_SET;
      end
      // the set cycle lets the memory's registered taps settle before the MAC samples them
      ST_TAP_SET: begin
        mem_dir = tap;
        state_n = ST_TAP_MAC;
      end
      ST_TAP_MAC: begin
        mem_dir = tap;
        state_n = (tap == TAP_Y2) ? ST_ROUND : ST_TAP_SET;
      end
      ST_ROUND: state_n = ST_COMMIT;
      ST_COMMIT: begin
        mem_y_enable = 1'b1;
        y_valid      = 1'b1;
        state_n      = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    coef_sel = '0;
    case (tap)
      TAP_X0:  coef_sel = coef[0];
      TAP_X1:  coef_sel = coef[1];
      TAP_X2:  coef_sel = coef[2];
      TAP_Y1:  coef_sel = coef[3];
      TAP_Y2:  coef_sel = coef[4];
      default: coef_sel = '0;
    endcase
  end

  assign prod     = coef_sel * $signed(mem_out);
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tap   <= TAP_X0;
      acc   <= '0;
      mem_x <= '0;
      mem_y <= '0;
      y_out <= '0;
      for (int i = 0; i < 5; i++) coef[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: if (x_valid) begin
          mem_x   <= x_in;
          coef[0] <= $signed(b0);
          coef[1] <= $signed(b1);
          coef[2] <= $signed(b2);
          coef[3] <= $signed(a1);
          coef[4] <= $signed(a2);
          acc     <= '0;
        end
        ST_LOAD: tap <= TAP_X0;
        // feed-forward taps add, feedback taps subtract
        ST_TAP_MAC: begin
          acc <= (tap <= TAP_X2) ? acc + prod_ext : acc - prod_ext;
          tap <= tap + 3'd1;
        end
        ST_ROUND: begin
          mem_y <= result;
          y_out <= result;
        end
        default: ;
      endcase
    end
  end

  biquad_round_sat #(
    .ACC_W (ACC_W),
    .DATA_W(DATA_W),
    .FRAC_W(FRAC_W)
  ) u_round (
    .acc   (acc),
    .result(result)
  );

endmodule

// File: tb/tb_iir_biquad_mac_seq.sv
// Bench for iir_biquad_mac_seq: behavioural tap memory plus a reference biquad feeding a scoreboard.
module tb_iir_biquad_mac_seq;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic        [31:0] x_in = '0;
  logic               x_valid = 1'b0;
  logic               x_ready;
  logic signed [17:0] b0 = '0, b1 = '0, b2 = '0, a1 = '0, a2 = '0;
  logic        [31:0] mem_out;
  logic        [2:0]  mem_dir;
  logic        [31:0] mem_x, mem_y;
  logic               mem_x_enable, mem_y_enable;
  logic        [31:0] y_out;
  logic               y_valid, busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc = -100;
  bit chk_rdy = 1'b0;

  logic [31:0] exp_q[$];
  int          acc_q[$];
  logic signed [31:0] mx1 = '0, mx2 = '0, my1 = '0, my2 = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iir_biquad_mac_seq dut (
    .clk         (clk),
    .reset       (reset),
    .x_in        (x_in),
    .x_valid     (x_valid),
    .x_ready     (x_ready),
    .b0          (b0),
    .b1          (b1),
    .b2          (b2),
    .a1          (a1),
    .a2          (a2),
    .mem_out     (mem_out),
    .mem_dir     (mem_dir),
    .mem_x       (mem_x),
    .mem_y       (mem_y),
    .mem_x_enable(mem_x_enable),
    .mem_y_enable(mem_y_enable),
    .y_out       (y_out),
    .y_valid     (y_valid),
    .busy        (busy)
  );

  // tap memory: taps 0 and 3 pass through, taps 1, 2, 4 are registered one cycle
  logic [31:0] xr0, xr1, xr2, yr0, yr1, tap_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xr0 <= '0; xr1 <= '0; xr2 <= '0; yr0 <= '0; yr1 <= '0; tap_q <= '0;
    end else begin
      if (mem_x_enable) begin xr0 <= mem_x; xr1 <= xr0; xr2 <= xr1; end
      if (mem_y_enable) begin yr0 <= mem_y; yr1 <= yr0; end
      case (mem_dir)
        3'd1:    tap_q <= xr1;
        3'd2:    tap_q <= xr2;
        3'd4:    tap_q <= yr1;
        default: tap_q <= '0;
      endcase
    end
  end
  assign mem_out = (mem_dir == 3'd0) ? mem_x : (mem_dir == 3'd3) ? mem_y : tap_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic model_push(input logic signed [31:0] x);
    longint acc, q;
    logic [31:0] r;
    acc = longint'(b0) * x + longint'(b1) * mx1 + longint'(b2) * mx2
        - longint'(a1) * my1 - longint'(a2) * my2;
    q = (acc + 64'sd32768) >>> 16;
`ifdef IIR_BIQUAD_SAT_EN
    if (q > 64'sd2147483647)       r = 32'h7FFF_FFFF;
    else if (q < -64'sd2147483648) r = 32'h8000_0000;
    else                           r = q[31:0];
`else
    r = q[31:0];
`endif
    mx2 = mx1; mx1 = x; my2 = my1; my1 = r;
    exp_q.push_back(r);
  endtask

  // called #1 after a rising edge; returns #1 after the accept edge
  task automatic send(input logic signed [31:0] x, input bit hold, output int acc_cyc);
    int n;
    x_in = x;
    x_valid = 1'b1;
    n = 0;
    acc_cyc = -1;
    @(negedge clk);
    while (!x_ready && n < 40) begin @(negedge clk); n++; end
    if (!x_ready) begin
      check("accept_timeout", {31'd0, x_ready}, 32'd1);
      x_valid = 1'b0;
      return;
    end
    model_push(x);
    acc_cyc = cyc + 1;
    last_acc = acc_cyc;
    acc_q.push_back(acc_cyc);
    @(posedge clk); #1;
    if (!hold) x_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(posedge clk); n++; end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    x_valid = 1'b0;
    reset = 1'b1;
    exp_q.delete(); acc_q.delete();
    mx1 = '0; mx2 = '0; my1 = '0; my2 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic set_coef(input int c0, input int c1, input int c2, input int c3, input int c4);
    b0 = 18'(c0); b1 = 18'(c1); b2 = 18'(c2); a1 = 18'(c3); a2 = 18'(c4);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (y_valid) begin
        if (exp_q.size() == 0) check("unexpected_y_valid", {31'd0, y_valid}, 32'd0);
        else begin
          check("y_out", y_out, exp_q.pop_front());
          check("latency", cyc, acc_q.pop_front() + 12);
        end
      end
      if (mem_x_enable) check("x_enable_cycle", cyc, last_acc);
      if (chk_rdy) check("ready_vs_busy", {31'd0, x_ready}, {31'd0, ~busy});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2;
    // reset state
    repeat (2) @(negedge clk);
    check("rst_x_ready", {31'd0, x_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_y_out", y_out, 32'd0);
    check("rst_y_valid", {31'd0, y_valid}, 32'd0);
    check("rst_mem_dir", {29'd0, mem_dir}, 32'd0);
    check("rst_mem_x", mem_x, 32'd0);
    check("rst_mem_y", mem_y, 32'd0);
    check("rst_enables", {30'd0, mem_x_enable, mem_y_enable}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("ready_after_release", {31'd0, x_ready}, 32'd1);
    @(posedge clk); #1;

    // passthrough
    set_coef(65536, 0, 0, 0, 0);
    send(1000, 1'b0, t1);
    drain();

    // feedback impulse: 1000, 500, 250
    do_reset();
    set_coef(65536, 0, 0, -32768, 0);
    send(1000, 1'b0, t1);
    send(0, 1'b0, t1);
    send(0, 1'b0, t1);
    drain();

    // round half up: 1.5 -> 2, -1.5 -> -1
    do_reset();
    set_coef(32768, 0, 0, 0, 0);
    send(3, 1'b0, t1);
    send(-3, 1'b0, t1);
    drain();

    // overflow: saturate or wrap depending on build
    do_reset();
    set_coef(98304, 0, 0, 0, 0);
    send(32'h7FFF_FFFF, 1'b0, t1);
    drain();

    // all five taps with distinct coefficients
    do_reset();
    set_coef(20000, -15000, 9000, -30000, 12000);
    for (int i = 0; i < 6; i++) send($signed(32'($urandom_range(200000, 0))) - 100000, 1'b0, t1);
    drain();

    // back-to-back with x_valid held; mid-run coefficient change applies to second sample
    do_reset();
    chk_rdy = 1'b1;
    set_coef(65536, 0, 0, 0, 0);
    send(100, 1'b1, t1);
    x_in = 200;
    repeat (3) @(posedge clk);
    #1 b0 = 18'sd131072 - 18'sd1;
    b0 = 18'h1FFFF;
    set_coef(131071, 0, 0, 0, 0);
    send(200, 1'b0, t2);
    check("accept_spacing", t2 - t1, 32'd14);
    drain();
    chk_rdy = 1'b0;

    // reset during TAP_MAC 2 aborts the sample
    do_reset();
    set_coef(65536, 0, 0, 0, 0);
    send(1234, 1'b0, t1);
    repeat (6) @(posedge clk);
    #2;
    check("pre_abort_dir", {29'd0, mem_dir}, 32'd2);
    reset = 1'b1;
    #1;
    exp_q.delete(); acc_q.delete();
    mx1 = '0; mx2 = '0; my1 = '0; my2 = '0;
    check("abort_y_out", y_out, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_mem_x", mem_x, 32'd0);
    check("abort_pulses", {29'd0, y_valid, mem_x_enable, mem_y_enable}, 32'd0);
    check("abort_mem_dir", {29'd0, mem_dir}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    send(1000, 1'b0, t1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
